left_shift_iter: RTL

- Multi-cycle logical left shifter; complements the arithmetic right-shift stage used in the ALU shift path.
- Uses one log-shift stage per cycle (16, 8, 4, 2, 1), selected by the shift-amount bits, MSB stage first.
- Start/busy/done handshake, so the pipeline can stall on shift ops and hold only one shift stage's logic per cycle.
- Sits beside the ALU and is driven by the execute-stage controller.

---
 rtl/left_shift_iter.sv | 111 +++++++++++
 1 files changed

// File: rtl/left_shift_iter.sv
// Iterative logical left shifter: one power-of-two shift stage per cycle,
// from the MSB stage down to the 1-bit stage, behind a start/busy/done handshake.
// Optional build macro LSHIFT_EARLY_EXIT_EN: finishes as soon as no lower
// shift-amount bits remain set, and skips the shift phase for shamt == 0.
module left_shift_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   shift,
    output logic               busy,
    output logic               done
);

    localparam int unsigned IdxW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [IdxW-1:0] IdxMax = IdxW'(SHAMT_W - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   stage_d;
    logic [SHAMT_W-1:0] shamt_q;
    logic [IdxW-1:0]    idx_q;
    logic               busy_q;
    logic               done_q;
    logic               last_stage;

    // Apply the single stage selected by idx_q if its shift-amount bit is set.
    always_comb begin
        stage_d = shift_q;
        if (shamt_q[idx_q]) begin
            stage_d = shift_q << (32'd1 << idx_q);
        end
    end

`ifdef LSHIFT_EARLY_EXIT_EN
    logic [SHAMT_W-1:0] low_mask;

    // Current stage is the last one that does work when no lower bits are set.
    always_comb begin
        low_mask   = (SHAMT_W'(1) << idx_q) - SHAMT_W'(1);
        last_stage = (idx_q == '0) || ((shamt_q & low_mask) == '0);
    end
`else
    // Fixed latency: always walk down to the 1-bit stage.
    always_comb begin
        last_stage = (idx_q == '0);
    end
`endif

    // Handshake FSM with registered result, busy and done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            shamt_q <= '0;
            idx_q   <= IdxMax;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q <= A;
                        shamt_q <= shamt;
                        idx_q   <= IdxMax;
`ifdef LSHIFT_EARLY_EXIT_EN
                        if (shamt == '0) begin
                            // Nothing to shift: result is A, report next cycle.
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StShift;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= StShift;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                StShift: begin
                    shift_q <= stage_d;
                    done_q  <= 1'b0;
                    if (last_stage) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q - IdxW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign shift = shift_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
